// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
package arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   // Rotate right: result bit i is v[(i + sh) mod 4].
   function automatic logic [N_REQ-1:0] rotr4(input logic [N_REQ-1:0] v, input logic [IDX_W-1:0] sh);
      logic [2*N_REQ-1:0] t;
      t = {v, v} >> sh;
      return t[N_REQ-1:0];
   endfunction

   function automatic logic [N_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] r;
      r = 4'b0001 << idx;
      return r;
   endfunction

endpackage

// File: rtl/prio_enc4.sv
// Lowest-set-bit priority encoder over four inputs; purely combinational.
// Zero latency; no flow control.
module prio_enc4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] in,
   output logic [IDX_W-1:0] out,
   output logic             valid
);

   always_comb begin
      out = 2'd0;
      if (in[0])      out = 2'd0;
      else if (in[1]) out = 2'd1;
      else if (in[2]) out = 2'd2;
      else if (in[3]) out = 2'd3;
   end

   assign valid = |in;

endmodule

// File: rtl/rr_arbiter4.sv
// Registered 4-way round-robin arbiter with bounded hold; grant follows req by one cycle.
// A contested owner is pre-empted after MAX_HOLD cycles (0 disables pre-emption).
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             busy,
   output logic             expired
);

   localparam int            HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HOLD_ONE = HW'(1);

   state_t            state, state_n;
   logic [IDX_W-1:0]  ptr, ptr_n;
   logic [HW-1:0]     hold_cnt, hold_n;
   logic [N_REQ-1:0]  grant_n;
   logic [IDX_W-1:0]  idx_n;
   logic              exp_n;

   logic [IDX_W-1:0]  owner;
   logic [N_REQ-1:0]  others;
   logic              release_c, timeout_c;
   logic [IDX_W-1:0]  arb_ptr;
   logic [N_REQ-1:0]  arb_req, rot_req;
   logic [IDX_W-1:0]  enc_out, winner;
   logic              enc_valid;

   // While owning, the search always starts just past the owner and excludes it,
   // which covers both release and timeout with a single encoder.
   always_comb begin
      owner     = grant_idx;
      others    = req & ~onehot4(owner);
      release_c = (state == ST_OWN) && !req[owner];
      timeout_c = (state == ST_OWN) && (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && (|others);
      arb_ptr   = (state == ST_OWN) ? owner + 2'd1 : ptr;
      arb_req   = (state == ST_OWN) ? others : req;
      rot_req   = rotr4(arb_req, arb_ptr);
   end

   prio_enc4 u_enc (
      .in    (rot_req),
      .out   (enc_out),
      .valid (enc_valid)
   );

   assign winner = enc_out + arb_ptr;

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      hold_n  = hold_cnt;
      grant_n = grant;
      idx_n   = grant_idx;
      exp_n   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enc_valid) begin
               state_n = ST_OWN;
               grant_n = onehot4(winner);
               idx_n   = winner;
               hold_n  = HOLD_ONE;
            end else begin
               grant_n = '0;
               idx_n   = '0;
               hold_n  = '0;
            end
         end
         ST_OWN: begin
            if (release_c || timeout_c) begin
               ptr_n = arb_ptr;
               if (enc_valid) begin
                  grant_n = onehot4(winner);
                  idx_n   = winner;
                  hold_n  = HOLD_ONE;
                  exp_n   = timeout_c && !release_c;
               end else begin
                  state_n = ST_IDLE;
                  grant_n = '0;
                  idx_n   = '0;
                  hold_n  = '0;
               end
            end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_MAX)) begin
               hold_n = hold_cnt + HOLD_ONE;
            end
         end
         default: begin
            state_n = ST_IDLE;
            grant_n = '0;
            idx_n   = '0;
            hold_n  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         grant     <= '0;
         grant_idx <= '0;
         busy      <= 1'b0;
         expired   <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         hold_cnt  <= hold_n;
         grant     <= grant_n;
         grant_idx <= idx_n;
         busy      <= |grant_n;
         expired   <= exp_n;
      end
   end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: stimulus pushes expected outputs, a monitor pops and compares after each edge.
module tb_rr_arbiter4;

   logic       clk;
   logic       rst4, rst2;
   logic [3:0] req4, req2;
   logic [3:0] grant4, grant2;
   logic [1:0] idx4, idx2;
   logic       busy4, busy2, exp4, exp2;

   rr_arbiter4 #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst(rst4), .req(req4),
      .grant(grant4), .grant_idx(idx4), .busy(busy4), .expired(exp4)
   );

   rr_arbiter4 #(.MAX_HOLD(2)) dut2 (
      .clk(clk), .rst(rst2), .req(req2),
      .grant(grant2), .grant_idx(idx2), .busy(busy2), .expired(exp2)
   );

   typedef struct {
      bit         sel;
      logic [3:0] grant;
      logic [1:0] idx;
      logic       busy;
      logic       expired;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // sel=0 drives the MAX_HOLD=4 instance, sel=1 the MAX_HOLD=2 instance.
   task automatic step(input bit sel, input logic r, input logic [3:0] rq,
                       input logic [3:0] g, input logic [1:0] ix, input logic ex,
                       input string nm);
      exp_t e;
      @(negedge clk);
      if (sel) begin rst2 = r; req2 = rq; end
      else     begin rst4 = r; req4 = rq; end
      e.sel = sel; e.grant = g; e.idx = ix; e.busy = |g; e.expired = ex; e.name = nm;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [3:0] ag;
      logic [1:0] ai;
      logic       ab, ae;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            ag = e.sel ? grant2 : grant4;
            ai = e.sel ? idx2   : idx4;
            ab = e.sel ? busy2  : busy4;
            ae = e.sel ? exp2   : exp4;
            total++;
            if (ag !== e.grant || ai !== e.idx || ab !== e.busy || ae !== e.expired) begin
               bad++;
               $display("FAIL %s: got grant=%b idx=%0d busy=%b expired=%b, want grant=%b idx=%0d busy=%b expired=%b",
                        e.name, ag, ai, ab, ae, e.grant, e.idx, e.busy, e.expired);
            end
         end
      end
   end

   initial begin : stim
      int waited;
      rst4 = 1'b1; req4 = 4'b0000;
      rst2 = 1'b1; req2 = 4'b0000;

      // Reset with all requests high, then first grant.
      step(0, 1, 4'b1111, 4'b0000, 0, 0, "reset_a");
      step(0, 1, 4'b1111, 4'b0000, 0, 0, "reset_b");
      step(0, 0, 4'b1111, 4'b0001, 0, 0, "first_grant");

      // Rotation with MAX_HOLD=4.
      step(0, 1, 4'b0000, 4'b0000, 0, 0, "rot_reset");
      for (int i = 0; i < 4; i++) step(0, 0, 4'b0101, 4'b0001, 0, 0, "rot_own0");
      step(0, 0, 4'b0101, 4'b0100, 2, 1, "rot_to2");
      for (int i = 0; i < 3; i++) step(0, 0, 4'b0101, 4'b0100, 2, 0, "rot_own2");
      step(0, 0, 4'b0101, 4'b0001, 0, 1, "rot_to0");

      // Release handoff: ptr becomes 1, no idle cycle.
      step(0, 0, 4'b1010, 4'b0010, 1, 0, "release_to1");
      // Owner 1 releases, search from 2 finds 3.
      step(0, 0, 4'b1000, 4'b1000, 3, 0, "release_to3");
      // Wrap-around: ptr goes from 3 to 0.
      step(0, 0, 4'b0011, 4'b0001, 0, 0, "wrap_to0");
      // Owner 0 reaches hold 4, then releases on the same edge a timeout would fire.
      for (int i = 0; i < 3; i++) step(0, 0, 4'b0011, 4'b0001, 0, 0, "hold_own0");
      step(0, 0, 4'b0010, 4'b0010, 1, 0, "release_beats_timeout");
      // Go idle with ptr=2; ptr must survive the idle period.
      step(0, 0, 4'b0000, 4'b0000, 0, 0, "idle_a");
      step(0, 0, 4'b1011, 4'b1000, 3, 0, "idle_ptr_kept");
      step(0, 0, 4'b0000, 4'b0000, 0, 0, "idle_b");

      // Reset mid-grant while owner 2 holds with ptr=2.
      step(0, 0, 4'b0010, 4'b0010, 1, 0, "pre_own1");
      step(0, 0, 4'b0100, 4'b0100, 2, 0, "pre_own2");
      step(0, 1, 4'b0100, 4'b0000, 0, 0, "mid_reset");
      step(0, 0, 4'b0000, 4'b0000, 0, 0, "post_reset_idle");
      step(0, 0, 4'b1111, 4'b0001, 0, 0, "post_reset_ptr0");

      // Uncontested owner with MAX_HOLD=2.
      step(1, 1, 4'b0000, 4'b0000, 0, 0, "unc_reset");
      for (int i = 0; i < 10; i++) step(1, 0, 4'b0010, 4'b0010, 1, 0, "unc_own1");
      step(1, 0, 4'b0110, 4'b0100, 2, 1, "unc_timeout_to2");
      step(1, 0, 4'b0110, 4'b0100, 2, 0, "unc_own2");
      step(1, 0, 4'b0110, 4'b0010, 1, 1, "unc_timeout_to1");

      waited = 0;
      while (exp_q.size() != 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      #2;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
